dsp_out_accumulator: RTL

// - Downstream stage of the output-registered DSP block; consumes its registered DATA_WIDTH-bit product stream.
// - Sums COUNT valid products per frame into an ACC_WIDTH-bit accumulator.
// - Presents the frame result with a valid/ready handshake and a sticky overflow flag.
// - Provides a sequential load for the DSP/DFF packing tests.

---
 rtl/dsp_out_accumulator.sv | 81 ++++++++
 1 files changed

// File: rtl/dsp_out_accumulator.sv
// dsp_out_accumulator: sums COUNT DSP products per frame and hands the result off via valid/ready
module dsp_out_accumulator #(
    parameter int DATA_WIDTH = 4,
    parameter int ACC_WIDTH  = 8,
    parameter int COUNT      = 4,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic                  overflow,
    output logic                  busy
);
    localparam int CW = $clog2(COUNT + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t               state;
    logic [ACC_WIDTH-1:0] acc;
    logic [CW-1:0]        cnt;
    logic [ACC_WIDTH:0]   sum;
    logic [ACC_WIDTH-1:0] acc_next;
    logic                 last;

    // one-bit-wider add exposes the carry; clamp or wrap it back into ACC_WIDTH bits
    always_comb begin
        sum      = {1'b0, acc} + {{(ACC_WIDTH + 1 - DATA_WIDTH){1'b0}}, in_data};
        acc_next = (sum[ACC_WIDTH] && SATURATE) ? '1 : sum[ACC_WIDTH-1:0];
        last     = cnt == CW'(COUNT - 1);
    end

    // frame FSM with every output registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state    <= ACCUM;
                    acc      <= '0;
                    cnt      <= '0;
                    overflow <= 1'b0;
                    busy     <= 1'b1;
                end
                ACCUM: if (in_valid) begin
                    acc      <= acc_next;
                    cnt      <= cnt + CW'(1);
                    overflow <= overflow | sum[ACC_WIDTH];
                    if (last) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        out_data  <= acc_next;
                        busy      <= 1'b0;
                    end
                end
                HOLD: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= start ? ACCUM : IDLE;
                    if (start) begin
                        acc      <= '0;
                        cnt      <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
